// File: rtl/imem_block_responder.sv
// Instruction-memory responder: accepts a block read, holds BUSYWAIT for LATENCY
// cycles, then returns a 16-byte little-endian block. Byte-wide load port for preload.
module imem_block_responder #(
    parameter int LATENCY = 8,
    parameter int BLOCKS  = 64
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         READ,
    input  logic [5:0]   ADDRESS,
    output logic [127:0] READINST,
    output logic         BUSYWAIT,
    input  logic         LOAD_EN,
    input  logic [9:0]   LOAD_ADDR,
    input  logic [7:0]   LOAD_DATA
);

    localparam int MEM_BYTES = BLOCKS * 16;
    localparam int AW        = $clog2(MEM_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [5:0]   addr_q, addr_d;
    logic         busywait_q, busywait_d;
    logic [127:0] readinst_q, readinst_d;

    logic [7:0]    mem_q [MEM_BYTES];
    logic [127:0]  block_data;
    logic [AW-1:0] block_base;
    logic          load_we;

    // Block is sampled at completion, so a load accepted alongside READ is visible.
    always_comb begin
        block_data = '0;
        block_base = AW'({addr_q, 4'b0000});
        if ({26'b0, addr_q} < 32'(BLOCKS)) begin
            for (int k = 0; k < 16; k++) begin
                block_data[8*k +: 8] = mem_q[block_base + AW'(k)];
            end
        end
    end

    assign load_we = !RESET && (state_q == ST_IDLE) && LOAD_EN
                     && ({22'b0, LOAD_ADDR} < 32'(MEM_BYTES));

    always_ff @(posedge CLK) begin
        if (load_we) begin
            mem_q[AW'(LOAD_ADDR)] <= LOAD_DATA;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        busywait_d = busywait_q;
        readinst_d = readinst_q;
        case (state_q)
            ST_IDLE: begin
                if (READ) begin
                    addr_d     = ADDRESS;
                    busywait_d = 1'b1;
                    cnt_d      = 8'(LATENCY - 1);
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    readinst_d = block_data;
                    busywait_d = 1'b0;
                    state_d    = ST_DONE;
                end
            end
            // One dead cycle so a READ dropped a cycle late does not refetch.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            addr_q     <= 6'd0;
            busywait_q <= 1'b0;
            readinst_q <= 128'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            busywait_q <= busywait_d;
            readinst_q <= readinst_d;
        end
    end

    assign READINST = readinst_q;
    assign BUSYWAIT = busywait_q;

endmodule

// File: tb/tb_imem_block_responder.sv
// Scoreboard bench for imem_block_responder: a byte-array model produces the expected
// block when each request is issued; results are popped when BUSYWAIT falls.
module tb_imem_block_responder;

    localparam int LAT = 8;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         READ;
    logic [5:0]   ADDRESS;
    logic [127:0] READINST;
    logic         BUSYWAIT;
    logic         LOAD_EN;
    logic [9:0]   LOAD_ADDR;
    logic [7:0]   LOAD_DATA;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q [$];
    logic [7:0]   model_mem [1024];

    imem_block_responder #(.LATENCY(LAT), .BLOCKS(64)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .READ      (READ),
        .ADDRESS   (ADDRESS),
        .READINST  (READINST),
        .BUSYWAIT  (BUSYWAIT),
        .LOAD_EN   (LOAD_EN),
        .LOAD_ADDR (LOAD_ADDR),
        .LOAD_DATA (LOAD_DATA)
    );

    always #5 CLK = ~CLK;

    function automatic logic [127:0] model_block(input logic [5:0] a);
        logic [127:0] b;
        for (int k = 0; k < 16; k++) b[8*k +: 8] = model_mem[{a, 4'b0000} + 10'(k)];
        return b;
    endfunction

    // Inputs change and outputs are sampled on the falling edge.
    task automatic load_byte(input logic [9:0] a, input logic [7:0] d);
        LOAD_EN = 1'b1; LOAD_ADDR = a; LOAD_DATA = d;
        model_mem[a] = d;
        @(negedge CLK);
        LOAD_EN = 1'b0;
    endtask

    task automatic issue_read(input logic [5:0] a, input bit hold);
        READ = 1'b1; ADDRESS = a;
        exp_q.push_back(model_block(a));
        @(negedge CLK);
        if (!hold) READ = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (BUSYWAIT === 1'b1 && n < 300) begin
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; READ = 1'b1; ADDRESS = 6'd1;
        LOAD_EN = 1'b0; LOAD_ADDR = '0; LOAD_DATA = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checks++;
            if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_busywait: got %b expected 0", BUSYWAIT); end
            checks++;
            if (READINST !== 128'h0) begin errors++; $display("FAIL reset_readinst: got %h expected 0", READINST); end
        end
        RESET = 1'b0; READ = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_idle: busywait got %b expected 0", BUSYWAIT); end
    endtask

    task automatic preload();
        for (int b = 0; b < 6; b++)
            if (b != 1)
                for (int k = 0; k < 16; k++) load_byte(10'(b * 16 + k), 8'($urandom_range(0, 255)));
    endtask

    task automatic test_basic_fetch();
        int n;
        logic [127:0] e;
        for (int i = 0; i < 16; i++) load_byte(10'h10 + 10'(i), 8'(i));
        issue_read(6'd1, 1'b0);
        checks++;
        if (BUSYWAIT !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b expected 1", BUSYWAIT); end
        wait_done(n);
        checks++;
        if (n !== LAT) begin errors++; $display("FAIL basic_busy_len: got %0d expected %0d", n, LAT); end
        checks++;
        if (READINST !== 128'h0F0E0D0C0B0A09080706050403020100) begin
            errors++; $display("FAIL basic_const: got %h expected 0f0e0d0c0b0a09080706050403020100", READINST);
        end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL basic_queue: got empty expected 1 entry"); end
        else begin
            e = exp_q.pop_front();
            if (READINST !== e) begin errors++; $display("FAIL basic_data: got %h expected %h", READINST, e); end
        end
        @(negedge CLK);
    endtask

    task automatic test_addr_change();
        int n;
        logic [127:0] e;
        issue_read(6'd2, 1'b0);
        ADDRESS = 6'd5;
        @(negedge CLK);
        READ = 1'b1;
        @(negedge CLK);
        READ = 1'b0;
        wait_done(n);
        checks++;
        if (n !== LAT - 2) begin errors++; $display("FAIL addr_busy_len: got %0d expected %0d", n, LAT - 2); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL addr_queue: got empty expected 1 entry"); end
        else begin
            e = exp_q.pop_front();
            if (READINST !== e) begin errors++; $display("FAIL addr_data: got %h expected %h", READINST, e); end
        end
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        int n;
        logic [127:0] e;
        // READ held through DONE then dropped: exactly one return
        issue_read(6'd3, 1'b1);
        wait_done(n);
        checks++;
        if (n !== LAT) begin errors++; $display("FAIL late_busy_len: got %0d expected %0d", n, LAT); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL late_queue: got empty expected 1 entry"); end
        else begin
            e = exp_q.pop_front();
            if (READINST !== e) begin errors++; $display("FAIL late_data: got %h expected %h", READINST, e); end
        end
        @(negedge CLK);
        checks++;
        if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL late_done_ignored: got %b expected 0", BUSYWAIT); end
        READ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL late_no_refetch: got %b expected 0", BUSYWAIT); end
        end
        checks++;
        if (READINST !== e) begin errors++; $display("FAIL late_hold: got %h expected %h", READINST, e); end
        // READ held into IDLE: second fetch accepted LAT+2 edges after the first
        issue_read(6'd5, 1'b1);
        wait_done(n);
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_queue0: got empty expected 1 entry"); end
        else begin
            e = exp_q.pop_front();
            if (READINST !== e) begin errors++; $display("FAIL b2b_data0: got %h expected %h", READINST, e); end
        end
        @(negedge CLK);
        checks++;
        if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL b2b_done: got %b expected 0", BUSYWAIT); end
        exp_q.push_back(model_block(6'd5));
        @(negedge CLK);
        READ = 1'b0;
        checks++;
        if (BUSYWAIT !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", BUSYWAIT); end
        wait_done(n);
        checks++;
        if (n !== LAT) begin errors++; $display("FAIL b2b_busy_len: got %0d expected %0d", n, LAT); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_queue1: got empty expected 1 entry"); end
        else begin
            e = exp_q.pop_front();
            if (READINST !== e) begin errors++; $display("FAIL b2b_data1: got %h expected %h", READINST, e); end
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        int n;
        logic [127:0] e;
        issue_read(6'd4, 1'b0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        exp_q.delete();
        checks++;
        if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL rstmid_busywait: got %b expected 0", BUSYWAIT); end
        checks++;
        if (READINST !== 128'h0) begin errors++; $display("FAIL rstmid_readinst: got %h expected 0", READINST); end
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge CLK);
            checks++;
            if (BUSYWAIT !== 1'b0 || READINST !== 128'h0) begin
                errors++; $display("FAIL rstmid_no_return: busy %b data %h expected 0 and 0", BUSYWAIT, READINST);
            end
        end
        issue_read(6'd4, 1'b0);
        wait_done(n);
        checks++;
        if (n !== LAT) begin errors++; $display("FAIL rstmid_fresh_len: got %0d expected %0d", n, LAT); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rstmid_queue: got empty expected 1 entry"); end
        else begin
            e = exp_q.pop_front();
            if (READINST !== e) begin errors++; $display("FAIL rstmid_data: got %h expected %h", READINST, e); end
        end
        @(negedge CLK);
    endtask

    task automatic test_load_interaction();
        int n;
        logic [127:0] e;
        logic [7:0] old_byte;
        old_byte = model_mem[10'h20];
        issue_read(6'd0, 1'b0);
        LOAD_EN = 1'b1; LOAD_ADDR = 10'h20; LOAD_DATA = ~old_byte;
        @(negedge CLK);
        LOAD_EN = 1'b0;
        wait_done(n);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge CLK);
        issue_read(6'd2, 1'b0);
        wait_done(n);
        checks++;
        if (READINST[7:0] !== old_byte) begin errors++; $display("FAIL busy_load_ignored: got %h expected %h", READINST[7:0], old_byte); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL busy_load_queue: got empty expected 1 entry"); end
        else begin
            e = exp_q.pop_front();
            if (READINST !== e) begin errors++; $display("FAIL busy_load_data: got %h expected %h", READINST, e); end
        end
        @(negedge CLK);
        LOAD_EN = 1'b1; LOAD_ADDR = 10'h20; LOAD_DATA = 8'hAB;
        model_mem[10'h20] = 8'hAB;
        READ = 1'b1; ADDRESS = 6'd2;
        exp_q.push_back(model_block(6'd2));
        @(negedge CLK);
        LOAD_EN = 1'b0; READ = 1'b0;
        wait_done(n);
        checks++;
        if (n !== LAT) begin errors++; $display("FAIL simul_busy_len: got %0d expected %0d", n, LAT); end
        checks++;
        if (READINST[7:0] !== 8'hAB) begin errors++; $display("FAIL simul_byte: got %h expected ab", READINST[7:0]); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL simul_queue: got empty expected 1 entry"); end
        else begin
            e = exp_q.pop_front();
            if (READINST !== e) begin errors++; $display("FAIL simul_data: got %h expected %h", READINST, e); end
        end
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        preload();
        test_basic_fetch();
        test_addr_change();
        test_back_to_back();
        test_reset_mid();
        test_load_interaction();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_block_responder.md
# imem_block_responder

Instruction-memory responder for the instruction cache's block-fetch handshake. It accepts a block read request (`READ` + 6-bit block address), holds `BUSYWAIT` high for a fixed, parameterised latency, then returns a 128-bit block of 16 bytes. It sits between the instruction cache (the initiator) and the byte-wide instruction store. It also provides a byte-wide load port so benches and boot logic can preload program bytes.

## Interface
- `LATENCY`, default 8: cycles from request acceptance to data return; legal range 1..255.
- `BLOCKS`, default 64: number of 16-byte blocks (store size = `BLOCKS`*16 bytes).

- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `READ`  in  1  block read request from the cache.
- `ADDRESS`  in  6  block address; byte base = `ADDRESS`*16.
- `READINST`  out  128  returned block, registered.
- `BUSYWAIT`  out  1  high while a request is in service, registered.
- `LOAD_EN`  in  1  byte write strobe for preloading.
- `LOAD_ADDR`  in  10  byte address for the load port.
- `LOAD_DATA`  in  8  byte to store.

## Operation
- Storage is a byte array `mem[0 .. BLOCKS*16-1]`. `RESET` does not clear it.
- Return byte order is little-endian within the block: `READINST[8k+7:8k]` = `mem[ADDRESS*16 + k]`, for k = 0..15.
- State machine (IDLE, BUSY, DONE) plus an 8-bit down-counter `cnt`:
  - **IDLE:** if `READ`=1 at the edge, latch `ADDRESS` into `addr_q`, set `BUSYWAIT`<=1 and `cnt`<=`LATENCY`-1, and go to BUSY. Otherwise stay in IDLE.
  - **BUSY:**
    - If `cnt`!=0: `cnt`<=`cnt`-1.
    - If `cnt`==0: `READINST`<=block(`addr_q`), `BUSYWAIT`<=0, go to DONE.
    - `ADDRESS` and `READ` changes are ignored while in BUSY.
  - **DONE:** unconditionally go to IDLE. A `READ` high in DONE is not accepted; it is accepted at the next IDLE edge if still high. This is how a cache that drops `READ` one cycle late avoids a double fetch.
- `READINST` holds its last returned value until the next completion.
- Load port:
  - A write happens only when the state is IDLE and `LOAD_EN`=1: `mem[LOAD_ADDR]`<=`LOAD_DATA`.
  - `LOAD_EN` is ignored in BUSY and DONE.
  - If `LOAD_ADDR` >= `BLOCKS`*16, the write is dropped.
- Simultaneous `LOAD_EN` and `READ` in IDLE: both take effect on the same edge. The fetch returns the newly written byte, because data is sampled at completion, not at acceptance.
- Block addresses with `ADDRESS` >= `BLOCKS` return all zeros.

## Timing
- Reset values: state=IDLE, `BUSYWAIT`=0, `READINST`=128'h0, `cnt`=0, `addr_q`=0.
- `RESET` takes priority over all other inputs at any edge. Asserting it during BUSY aborts the fetch: `BUSYWAIT` is 0 and `READINST` is 0 after the edge, and no data is returned for the aborted request.
- Latency: `READ` is sampled at edge E0. `BUSYWAIT`=1 after E0. `READINST` is valid and `BUSYWAIT`=0 after edge E0+`LATENCY`.
- `LATENCY`=1: completion occurs at E0+1, so `BUSYWAIT` is high for exactly one cycle.
- Back-to-back requests: the minimum request-to-request spacing is `LATENCY`+2 edges (BUSY, then DONE, then IDLE accept).
- No combinational path from any input to any output.

## Test plan
- **Reset:** hold `RESET`=1 for 2 cycles with `READ`=1. Expect `BUSYWAIT`=0 and `READINST`=0 throughout, and IDLE after release.
- **Basic fetch:**
  - Preload bytes 0x10..0x1F with values 0x00..0x0F, then READ `ADDRESS`=1 with `LATENCY`=8.
  - Expect `BUSYWAIT` high for exactly 8 cycles.
  - Then expect `READINST`=128'h0F0E0D0C0B0A09080706050403020100, with `BUSYWAIT` low on the same edge.
- **Address change mid-fetch:** request `ADDRESS`=2, then switch `ADDRESS` to 5 during BUSY. Expect block 2 returned.
- **Late `READ` drop:** keep `READ`=1 for one cycle after `BUSYWAIT` falls. Expect a single return, DONE→IDLE, and no second `BUSYWAIT` pulse unless `READ` is still high in IDLE.
- **Reset mid-operation:** assert `RESET` at cycle 3 of BUSY. Expect `BUSYWAIT`=0 and `READINST`=0 after that edge. A fresh READ then completes normally after `LATENCY` cycles.
- **Load/read interaction:**
  - `LOAD_EN` pulsed in BUSY to `LOAD_ADDR`=0x20: expect it to be ignored, so a later read of block 2 shows the old byte.
  - `LOAD_EN` and `READ` together in IDLE at `LOAD_ADDR`=0x20 with data 0xAB, `ADDRESS`=2: expect `READINST[7:0]`=0xAB.
